bitonic_sort8_pipe: RTL and testbench
=====================================

Name: bitonic_sort8_pipe

Overview:
- Parametrised, pipelined successor of the combinational 8-input bitonic stage blocks.
- Implements the full 8-input bitonic sorting network (stages S1, S2, S3) with one register bank after each stage.
- Adds valid/ready flow control, a per-frame ascending/descending mode and a configurable lane width.
- Sits between a sample-frame producer and downstream consumers (median/rank logic); accepts one 8-lane frame per cycle when not stalled.

Parameters:
- W, 8, width in bits of each lane value.
- N is fixed at 8 lanes (not a parameter).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input frame valid.
- in_ready  output  1  block can accept a frame this cycle.
- in_desc  input  1  frame mode: 0 = ascending, 1 = descending; sampled with the frame.
- in_data  input  8*W  lanes 0..7; lane i = in_data[i*W +: W].
- out_valid  output  1  sorted frame valid.
- out_ready  input  1  consumer accepts the output frame.
- out_data  output  8*W  sorted lanes, same packing as in_data.

Behaviour:
- Interface fixed: one clock `clk`; `reset` is synchronous and active-high.
- Reset (sampled at a clk edge with reset=1):
  - all stage valid bits cleared, so out_valid=0.
  - out_data = 0 and all stage data/mode registers = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset asserted mid-operation discards all in-flight frames; no partial output.
- Comparator definition:
  - "asc(a,b)": lane a <= min, lane b <= max.
  - "desc(a,b)": lane a <= max, lane b <= min.
  - Comparison is unsigned (see Optional Feature).
  - Equal values pass unchanged.
- S1, stage register R1: asc(0,1), desc(2,3), asc(4,5), desc(6,7).
- S2, stage register R2:
  - asc(0,2), asc(1,3), desc(4,6), desc(5,7);
  - then asc(0,1), asc(2,3), desc(4,5), desc(6,7).
- S3, stage register R3 = output:
  - asc(0,4), asc(1,5), asc(2,6), asc(3,7);
  - then asc(0,2), asc(1,3), asc(4,6), asc(5,7);
  - then asc(0,1), asc(2,3), asc(4,5), asc(6,7).
- Descending mode:
  - The S3 result is lane-reversed before R3 (out lane i = ascending lane 7-i).
  - in_desc is carried through R1/R2 alongside the data, so each frame uses its own mode.
- Pipeline control:
  - advance = out_ready | ~out_valid.
  - in_ready = advance (combinational).
  - When advance=1, R1<=S1(in), R2<=S2(R1), R3<=S3(R2), and valid bits shift (v1<=in_valid).
  - When advance=0, all stages hold.
- Latency: 3 cycles from an accepted frame (in_valid & in_ready) to out_valid, with no stall.
- Throughput: 1 frame/cycle.
- Bubbles (in_valid=0) propagate as invalid slots. Data in invalid slots is don't-care but still registered.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Input data is accepted only on in_valid & in_ready; in_data is ignored otherwise.
- Back-to-back frames with alternating in_desc must each be sorted per their own mode.
- No internal frame counter and no wrap-around state; the pipeline depth is the only storage (3 frames).

Optional Feature:
- Macro: BITONIC_SIGNED_EN.
- Defined: all comparators treat lanes as two's-complement signed W-bit values.
- Undefined: all comparators are unsigned.
- Network structure, latency and handshake are identical in both builds.

Test Plan:
- Basic ascending, W=8:
  - Stimulus: reset 2 cycles; in_data lanes 0..7 = {5,3,8,1,7,2,6,4}, in_desc=0, out_ready=1.
  - Response: out_valid exactly 3 cycles after acceptance, lanes = {1,2,3,4,5,6,7,8}.
- Mixed modes back-to-back:
  - Stimulus: frames {255,0,128,1,1,254,2,127} desc=1, then {9,9,0,9,0,0,9,0} desc=0, consecutive cycles.
  - Response: outputs on consecutive cycles: {255,254,128,127,2,1,1,0} then {0,0,0,0,9,9,9,9}.
- Backpressure:
  - Stimulus: stream 5 frames; hold out_ready=0 for 4 cycles once out_valid=1.
  - Response: in_ready=0 while stalled; out_data unchanged; all 5 frames emerge in order with none lost or duplicated.
- Reset mid-stream:
  - Stimulus: 2 frames in flight, assert reset for 1 cycle.
  - Response: next cycle out_valid=0 and out_data=0; neither frame appears later.
- Signed build (BITONIC_SIGNED_EN, W=8):
  - Stimulus: input {0x80,0x7F,0xFF,0x01,0x00,0xFE,0x02,0x81}, asc.
  - Response: {0x80,0x81,0xFE,0xFF,0x00,0x01,0x02,0x7F}.
  - Same input in the unsigned build -> {0x00,0x01,0x02,0x7F,0x80,0x81,0xFE,0xFF}.
- Width parametrisation (W=16):
  - Stimulus: {1000,65535,0,300,300,42,9999,1}, asc.
  - Response: {0,1,42,300,300,1000,9999,65535}, latency 3.

Source files
------------

// File: rtl/bitonic_sort8_pipe.sv
// Pipelined 8-lane bitonic sorter: S1/S2/S3 each followed by a register bank, valid/ready flow control.
// Optional build macro BITONIC_SIGNED_EN switches every comparator to two's-complement signed order.
module bitonic_sort8_pipe #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_desc,
    input  logic [8*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*W-1:0] out_data
);

    // Element i of the packed frame occupies bits [i*W +: W], matching the port packing.
    typedef logic [7:0][W-1:0] frame_t;

    function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BITONIC_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Compare-exchange; strict compare keeps equal values in place.
    function automatic frame_t cas(input frame_t f, input logic [2:0] a, input logic [2:0] b,
                                   input logic desc);
        frame_t r;
        logic   swap;
        r    = f;
        swap = desc ? greater(f[b], f[a]) : greater(f[a], f[b]);
        if (swap) begin
            r[a] = f[b];
            r[b] = f[a];
        end
        return r;
    endfunction

    function automatic frame_t stage1(input frame_t f);
        frame_t t;
        t = cas(f, 3'd0, 3'd1, 1'b0);
        t = cas(t, 3'd2, 3'd3, 1'b1);
        t = cas(t, 3'd4, 3'd5, 1'b0);
        t = cas(t, 3'd6, 3'd7, 1'b1);
        return t;
    endfunction

    function automatic frame_t stage2(input frame_t f);
        frame_t t;
        t = cas(f, 3'd0, 3'd2, 1'b0);
        t = cas(t, 3'd1, 3'd3, 1'b0);
        t = cas(t, 3'd4, 3'd6, 1'b1);
        t = cas(t, 3'd5, 3'd7, 1'b1);
        t = cas(t, 3'd0, 3'd1, 1'b0);
        t = cas(t, 3'd2, 3'd3, 1'b0);
        t = cas(t, 3'd4, 3'd5, 1'b1);
        t = cas(t, 3'd6, 3'd7, 1'b1);
        return t;
    endfunction

    // Final merge always sorts ascending; descending frames are produced by lane reversal.
    function automatic frame_t stage3(input frame_t f, input logic desc);
        frame_t t;
        frame_t r;
        t = cas(f, 3'd0, 3'd4, 1'b0);
        t = cas(t, 3'd1, 3'd5, 1'b0);
        t = cas(t, 3'd2, 3'd6, 1'b0);
        t = cas(t, 3'd3, 3'd7, 1'b0);
        t = cas(t, 3'd0, 3'd2, 1'b0);
        t = cas(t, 3'd1, 3'd3, 1'b0);
        t = cas(t, 3'd4, 3'd6, 1'b0);
        t = cas(t, 3'd5, 3'd7, 1'b0);
        t = cas(t, 3'd0, 3'd1, 1'b0);
        t = cas(t, 3'd2, 3'd3, 1'b0);
        t = cas(t, 3'd4, 3'd5, 1'b0);
        t = cas(t, 3'd6, 3'd7, 1'b0);
        r = t;
        if (desc) begin
            for (int i = 0; i < 8; i++) begin
                r[3'(i)] = t[3'(7 - i)];
            end
        end
        return r;
    endfunction

    frame_t in_frame;
    frame_t r1, r2, r3;
    logic   v1, v2, v3;
    logic   d1, d2;
    logic   advance;

    assign in_frame  = in_data;
    assign advance   = out_ready | ~v3;
    assign in_ready  = advance;
    assign out_valid = v3;
    assign out_data  = r3;

    // NOTE: non-blocking assignments let every bank capture the previous bank's pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else if (advance) begin
            r1 <= stage1(in_frame);
            d1 <= in_desc;
            v1 <= in_valid;
            r2 <= stage2(r1);
            d2 <= d1;
            v2 <= v1;
            r3 <= stage3(r2, d2);
            v3 <= v2;
        end
    end

endmodule

// File: tb/tb_bitonic_sort8_pipe.sv
// Directed self-checking bench for bitonic_sort8_pipe: W=8 instance for flow control/modes, W=16 for width.
module tb_bitonic_sort8_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_desc, out_valid, out_ready;
    logic [63:0] in_data, out_data;

    logic         in_valid16, in_ready16, out_valid16;
    logic [127:0] in_data16, out_data16;

    int compared   = 0;
    int mismatched = 0;
    int sent, got;
    logic [63:0] exp_signed_vec;

    always #5 clk = ~clk;

    bitonic_sort8_pipe #(.W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    bitonic_sort8_pipe #(.W(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16), .in_desc(1'b0),
        .in_data(in_data16), .out_valid(out_valid16), .out_ready(1'b1), .out_data(out_data16)
    );

    function automatic logic [63:0] p8(input int l0, input int l1, input int l2, input int l3,
                                       input int l4, input int l5, input int l6, input int l7);
        int          v[8];
        logic [63:0] r;
        v = '{l0, l1, l2, l3, l4, l5, l6, l7};
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = v[i][7:0];
        return r;
    endfunction

    function automatic logic [127:0] p16(input int l0, input int l1, input int l2, input int l3,
                                         input int l4, input int l5, input int l6, input int l7);
        int           v[8];
        logic [127:0] r;
        v = '{l0, l1, l2, l3, l4, l5, l6, l7};
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = v[i][15:0];
        return r;
    endfunction

    function automatic logic [63:0] bp_frame(input int k);
        return p8(k*10+7, k*10+3, k*10+5, k*10+1, k*10+6, k*10+0, k*10+4, k*10+2);
    endfunction

    function automatic logic [63:0] bp_exp(input int k);
        return p8(k*10+0, k*10+1, k*10+2, k*10+3, k*10+4, k*10+5, k*10+6, k*10+7);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_desc    = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid16 = 1'b0;
        in_data16  = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_out_valid", 128'(out_valid), 128'(1'b0));
        check("reset_out_data", 128'(out_data), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1'b1));

        // Basic ascending with exact latency
        in_valid = 1'b1;
        in_desc  = 1'b0;
        in_data  = p8(5, 3, 8, 1, 7, 2, 6, 4);
        tick();
        in_valid = 1'b0;
        in_data  = p8(99, 99, 99, 99, 99, 99, 99, 99);
        check("asc_lat1_valid", 128'(out_valid), 128'(1'b0));
        tick();
        check("asc_lat2_valid", 128'(out_valid), 128'(1'b0));
        tick();
        check("asc_lat3_valid", 128'(out_valid), 128'(1'b1));
        check("asc_data", 128'(out_data), 128'(p8(1, 2, 3, 4, 5, 6, 7, 8)));
        tick();
        check("asc_bubble_valid", 128'(out_valid), 128'(1'b0));

        // Mixed modes back-to-back
        in_valid = 1'b1;
        in_desc  = 1'b1;
        in_data  = p8(255, 0, 128, 1, 1, 254, 2, 127);
        tick();
        in_desc  = 1'b0;
        in_data  = p8(9, 9, 0, 9, 0, 0, 9, 0);
        tick();
        in_valid = 1'b0;
        in_desc  = 1'b1;
        tick();
        check("mix_desc_valid", 128'(out_valid), 128'(1'b1));
        check("mix_desc_data", 128'(out_data), 128'(p8(255, 254, 128, 127, 2, 1, 1, 0)));
        tick();
        check("mix_asc_valid", 128'(out_valid), 128'(1'b1));
        check("mix_asc_data", 128'(out_data), 128'(p8(0, 0, 0, 0, 9, 9, 9, 9)));
        tick();
        check("mix_drain_valid", 128'(out_valid), 128'(1'b0));

        // Backpressure: fill three stages, then stall the consumer for four cycles
        in_desc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = bp_frame(k);
            tick();
        end
        in_data   = bp_frame(3);
        out_ready = 1'b0;
        #1;
        check("bp_stall_ready", 128'(in_ready), 128'(1'b0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_hold_valid", 128'(out_valid), 128'(1'b1));
            check("bp_hold_data", 128'(out_data), 128'(bp_exp(0)));
            check("bp_hold_ready", 128'(in_ready), 128'(1'b0));
        end
        out_ready = 1'b1;
        sent = 3;
        got  = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            in_valid = (sent < 5);
            in_data  = bp_frame(sent);
            #1;
            if (out_valid) begin
                check("bp_order", 128'(out_data), 128'(bp_exp(got)));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_frames_out", 128'(got), 128'(5));
        check("bp_no_dup", 128'(out_valid), 128'(1'b0));

        // Reset mid-stream discards in-flight frames
        in_valid = 1'b1;
        in_data  = p8(8, 7, 6, 5, 4, 3, 2, 1);
        tick();
        in_data  = p8(1, 1, 2, 2, 3, 3, 4, 4);
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_valid", 128'(out_valid), 128'(1'b0));
        check("rst_mid_data", 128'(out_data), 128'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst_mid_no_ghost", 128'(out_valid), 128'(1'b0));
        end

        // Signedness of the comparators depends on the build
`ifdef BITONIC_SIGNED_EN
        exp_signed_vec = p8(8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h7F);
`else
        exp_signed_vec = p8(8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF);
`endif
        in_valid = 1'b1;
        in_desc  = 1'b0;
        in_data  = p8(8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'hFE, 8'h02, 8'h81);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("sign_valid", 128'(out_valid), 128'(1'b1));
        check("sign_data", 128'(out_data), 128'(exp_signed_vec));
        tick();

        // W=16 instance
        in_valid16 = 1'b1;
        in_data16  = p16(1000, 65535, 0, 300, 300, 42, 9999, 1);
        tick();
        in_valid16 = 1'b0;
        in_data16  = '0;
        check("w16_lat1_valid", 128'(out_valid16), 128'(1'b0));
        tick();
        check("w16_lat2_valid", 128'(out_valid16), 128'(1'b0));
        tick();
        check("w16_lat3_valid", 128'(out_valid16), 128'(1'b1));
        check("w16_data", out_data16, p16(0, 1, 42, 300, 300, 1000, 9999, 65535));
        check("w16_ready", 128'(in_ready16), 128'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
